ysyx_23060061_exec_ctrl: RTL and testbench
==========================================

Name: ysyx_23060061_exec_ctrl

Overview:
Multi-cycle sequencer that drives the single-issue NPC datapath through fetch, execute, memory and writeback phases, one instruction at a time. It consumes the decoder's control bundle (RegWrite, MemRW, PCSel, ebreak) and gates the architectural write enables (PC, register file, instruction register) so each instruction commits exactly once. It owns the valid/ready handshakes to the instruction-fetch and load/store memory ports. It also maintains a retired-instruction counter.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
CNT_W, 64, width of retired-instruction counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ifu_req_valid  out  1  fetch request to instruction memory
ifu_req_ready  in  1  instruction memory accepts request
ifu_resp_valid  in  1  fetched instruction on inst bus is valid
inst_we  out  1  latch fetched instruction into IR
dec_RegWrite  in  1  decoder RegWrite
dec_MemRW  in  2  decoder MemRW (00 idle, 10 read, 01 write)
dec_ebreak  in  1  decoder ebreak
dec_PCSel  in  1  decoder PCSel (0: pc+4, 1: ALU target)
lsu_req_valid  out  1  data memory request
lsu_req_wen  out  1  1 = store, 0 = load
lsu_req_ready  in  1  data memory accepts request
lsu_resp_valid  in  1  load data / store ack returned
pc_we  out  1  commit next PC
pc_sel  out  1  registered copy of dec_PCSel used with pc_we
rf_we  out  1  register-file write enable
halt  out  1  ebreak retired; core stopped
instret  out  CNT_W  retired instruction count
state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset (rst=1 at posedge): state=FETCH. All outputs 0, instret=0, halt=0. The datapath loads RESET_PC from the same rst. Reset mid-transaction abandons any outstanding request. Responses arriving in the first FETCH cycle after reset are ignored until a new request handshake occurs.
- States (3-bit): FETCH=0, IWAIT=1, EXEC=2, MREQ=3, MWAIT=4, WB=5, HALT=6.
- FETCH: ifu_req_valid=1. On ifu_req_ready go to IWAIT; otherwise hold, keeping valid asserted. Valid must not drop before ready.
- IWAIT: on ifu_resp_valid, pulse inst_we for one cycle and go to EXEC. The response may arrive the cycle after acceptance at earliest; there is no upper bound and no timeout.
- EXEC: decoder outputs are combinationally valid this cycle. Capture pc_sel<=dec_PCSel and a local copy of RegWrite/MemRW.
  - dec_ebreak=1: go to HALT.
  - MemRW=10 or 01: go to MREQ.
  - MemRW=11 is illegal; treat it as idle.
  - Otherwise: go to WB.
- MREQ: lsu_req_valid=1, lsu_req_wen=(MemRW==01). On lsu_req_ready go to MWAIT.
- MWAIT: on lsu_resp_valid go to WB.
- WB: single cycle. pc_we=1. rf_we=captured RegWrite; stores therefore give rf_we=0. instret += 1, wrapping at 2^CNT_W modulo. Next state is FETCH.
- HALT: pc_we=0, rf_we=0, halt=1, instret incremented once on entry (ebreak counts as retired). Absorbing state; only rst leaves it.
- Write enables are asserted only in WB, so at most one pc_we and one rf_we pulse per instruction.
- Minimum latencies (memories ready and responding in 1 cycle):
  - Non-memory instruction: FETCH, IWAIT, EXEC, WB = 4 cycles.
  - Load/store: 6 cycles.
- Simultaneous ready and resp in the same cycle as the request is not legal for either port. Any resp_valid outside IWAIT/MWAIT is ignored.
- All outputs are Moore, decoded from state plus captured registers. No combinational path from any input to any output.

Decomposition:
- Shared header (global.vh): state encodings (`ysyx_23060061_ST_*`) and MemRW encodings (`ysyx_23060061_MEM_IDLE/READ/WRITE`).
- The instret counter is a natural sub-module: ysyx_23060061_Counter (enable, sync reset, parameterised width).
- The FSM stays flat in this module.

Test Plan:
- addi with 1-cycle memories: rst held 2 cycles, then instruction fetched → inst_we at cycle 2, rf_we=1 and pc_we=1 at cycle 3, instret=1, state_dbg back to 0 at cycle 4.
- lw with lsu_req_ready delayed 3 cycles → lsu_req_valid held high 4 cycles with lsu_req_wen=0; rf_we pulses exactly once after lsu_resp_valid; total 9 cycles.
- sw (MemRW=01, RegWrite=0) → lsu_req_wen=1, WB gives pc_we=1, rf_we=0, instret increments.
- beq taken (PCSel=1) → pc_sel=1 during the WB pc_we pulse. Then inject a spurious ifu_resp_valid during EXEC → no extra inst_we.
- ebreak after 5 instructions → halt=1, instret=6, no further ifu_req_valid for 20 cycles. Then rst=1 → halt=0, instret=0, state_dbg=0.
- rst asserted in MWAIT → next cycle FETCH, lsu_req_valid=0. A late lsu_resp_valid is ignored, with no rf_we.

Source files
------------

// File: rtl/ysyx_23060061_exec_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_23060061_exec_ctrl_pkg                                          |
// | State and MemRW encodings shared by the execution sequencer.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ysyx_23060061_exec_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_IWAIT = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MREQ  = 3'd3,
    ST_MWAIT = 3'd4,
    ST_WB    = 3'd5,
    ST_HALT  = 3'd6
  } state_e;

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b10;
  localparam logic [1:0] MEM_WRITE = 2'b01;

  // 2'b11 is illegal and deliberately falls into the non-memory path.
  function automatic logic is_mem_op(input logic [1:0] memrw);
    return (memrw == MEM_READ) || (memrw == MEM_WRITE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060061_exec_ctrl_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_23060061_Counter                                                |
// | Enabled up-counter with synchronous reset, wraps modulo 2^WIDTH.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ysyx_23060061_Counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/ysyx_23060061_exec_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_23060061_exec_ctrl                                              |
// | Multi-cycle fetch/exec/mem/writeback sequencer with retire counter.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ysyx_23060061_exec_ctrl
  import ysyx_23060061_exec_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_resp_valid,
  output logic             inst_we,
  input  logic             dec_RegWrite,
  input  logic [1:0]       dec_MemRW,
  input  logic             dec_ebreak,
  input  logic             dec_PCSel,
  output logic             lsu_req_valid,
  output logic             lsu_req_wen,
  input  logic             lsu_req_ready,
  input  logic             lsu_resp_valid,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             rf_we,
  output logic             halt,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_dbg
);

  // The PC register itself lives in the datapath; only alignment is checked here.
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("RESET_PC must be word aligned");
  end

  state_e     state_q, state_d;
  logic       regwrite_q;
  logic [1:0] memrw_q;
  logic       pc_sel_q;
  logic       retire;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (ifu_req_ready)  state_d = ST_IWAIT;
      ST_IWAIT: if (ifu_resp_valid) state_d = ST_EXEC;
      ST_EXEC: begin
        if (dec_ebreak)                state_d = ST_HALT;
        else if (is_mem_op(dec_MemRW)) state_d = ST_MREQ;
        else                           state_d = ST_WB;
      end
      ST_MREQ:  if (lsu_req_ready)  state_d = ST_MWAIT;
      ST_MWAIT: if (lsu_resp_valid) state_d = ST_WB;
      ST_WB:    state_d = ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      regwrite_q <= 1'b0;
      memrw_q    <= MEM_IDLE;
      pc_sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_EXEC) begin
        regwrite_q <= dec_RegWrite;
        memrw_q    <= dec_MemRW;
        pc_sel_q   <= dec_PCSel;
      end
    end
  end

  // ebreak retires on the EXEC->HALT transition, so HALT already shows it counted.
  assign retire = (state_q == ST_WB) || ((state_q == ST_EXEC) && dec_ebreak);

  ysyx_23060061_Counter #(
    .WIDTH (CNT_W)
  ) u_instret (
    .clk     (clk),
    .rst     (rst),
    .en_i    (retire),
    .count_o (instret)
  );

  assign ifu_req_valid = (state_q == ST_FETCH);
  assign inst_we       = (state_q == ST_EXEC);
  assign lsu_req_valid = (state_q == ST_MREQ);
  assign lsu_req_wen   = (state_q == ST_MREQ) && (memrw_q == MEM_WRITE);
  assign pc_we         = (state_q == ST_WB);
  assign rf_we         = (state_q == ST_WB) && regwrite_q;
  assign pc_sel        = pc_sel_q;
  assign halt          = (state_q == ST_HALT);
  assign state_dbg     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060061_exec_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ysyx_23060061_exec_ctrl                                           |
// | Directed-vector bench for the execution sequencer.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ysyx_23060061_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid, ifu_req_ready = 1'b0, ifu_resp_valid = 1'b0;
  logic        inst_we;
  logic        dec_RegWrite = 1'b0, dec_ebreak = 1'b0, dec_PCSel = 1'b0;
  logic [1:0]  dec_MemRW = 2'b00;
  logic        lsu_req_valid, lsu_req_wen;
  logic        lsu_req_ready = 1'b0, lsu_resp_valid = 1'b0;
  logic        pc_we, pc_sel, rf_we, halt;
  logic [63:0] instret;
  logic [2:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0;
  int no_fetch;

  ysyx_23060061_exec_ctrl #(
    .RESET_PC (32'h8000_0000),
    .CNT_W    (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_resp_valid (ifu_resp_valid),
    .inst_we        (inst_we),
    .dec_RegWrite   (dec_RegWrite),
    .dec_MemRW      (dec_MemRW),
    .dec_ebreak     (dec_ebreak),
    .dec_PCSel      (dec_PCSel),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_resp_valid (lsu_resp_valid),
    .pc_we          (pc_we),
    .pc_sel         (pc_sel),
    .rf_we          (rf_we),
    .halt           (halt),
    .instret        (instret),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FETCH with 1-cycle ready and response; returns positioned in EXEC.
  task automatic fetch();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b1;
    tick();
    ifu_resp_valid = 1'b0;
  endtask

  task automatic decode(input logic rw, input logic [1:0] mrw, input logic sel, input logic eb);
    dec_RegWrite = rw;
    dec_MemRW    = mrw;
    dec_PCSel    = sel;
    dec_ebreak   = eb;
    tick();
    dec_RegWrite = 1'b0;
    dec_MemRW    = 2'b00;
    dec_PCSel    = 1'b0;
    dec_ebreak   = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("reset_state", 64'(state_dbg), 64'd0);
    chk("reset_instret", instret, 64'd0);
    chk("reset_halt", 64'(halt), 64'd0);
    chk("reset_pc_we", 64'(pc_we), 64'd0);
    chk("reset_fetch_valid", 64'(ifu_req_valid), 64'd1);

    // addi: FETCH, IWAIT, EXEC, WB
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready  = 1'b0;
    chk("addi_iwait", 64'(state_dbg), 64'd1);
    chk("addi_iwait_no_we", 64'(inst_we), 64'd0);
    ifu_resp_valid = 1'b1;
    tick();
    ifu_resp_valid = 1'b0;
    chk("addi_inst_we", 64'(inst_we), 64'd1);
    decode(1'b1, 2'b00, 1'b0, 1'b0);
    chk("addi_wb_state", 64'(state_dbg), 64'd5);
    chk("addi_rf_we", 64'(rf_we), 64'd1);
    chk("addi_pc_we", 64'(pc_we), 64'd1);
    chk("addi_wb_inst_we", 64'(inst_we), 64'd0);
    tick();
    chk("addi_back_fetch", 64'(state_dbg), 64'd0);
    chk("addi_instret", instret, 64'd1);

    // lw with lsu_req_ready delayed 3 cycles
    t0 = cyc;
    fetch();
    decode(1'b1, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("lw_req_valid_hold", 64'(lsu_req_valid), 64'd1);
      chk("lw_req_wen", 64'(lsu_req_wen), 64'd0);
      tick();
    end
    chk("lw_req_valid_last", 64'(lsu_req_valid), 64'd1);
    lsu_req_ready = 1'b1;
    tick();
    lsu_req_ready = 1'b0;
    chk("lw_mwait", 64'(state_dbg), 64'd4);
    chk("lw_mwait_no_rf_we", 64'(rf_we), 64'd0);
    lsu_resp_valid = 1'b1;
    tick();
    lsu_resp_valid = 1'b0;
    chk("lw_rf_we", 64'(rf_we), 64'd1);
    tick();
    chk("lw_rf_we_drop", 64'(rf_we), 64'd0);
    chk("lw_total_cycles", 64'(cyc - t0), 64'd9);
    chk("lw_instret", instret, 64'd2);

    // sw
    fetch();
    decode(1'b0, 2'b01, 1'b0, 1'b0);
    chk("sw_req_wen", 64'(lsu_req_wen), 64'd1);
    lsu_req_ready = 1'b1;
    tick();
    lsu_req_ready  = 1'b0;
    lsu_resp_valid = 1'b1;
    tick();
    lsu_resp_valid = 1'b0;
    chk("sw_pc_we", 64'(pc_we), 64'd1);
    chk("sw_rf_we", 64'(rf_we), 64'd0);
    tick();
    chk("sw_instret", instret, 64'd3);

    // beq taken with spurious fetch response during EXEC
    fetch();
    ifu_resp_valid = 1'b1;
    decode(1'b0, 2'b00, 1'b1, 1'b0);
    ifu_resp_valid = 1'b0;
    chk("beq_pc_we", 64'(pc_we), 64'd1);
    chk("beq_pc_sel", 64'(pc_sel), 64'd1);
    chk("beq_no_extra_inst_we", 64'(inst_we), 64'd0);
    tick();
    chk("beq_instret", instret, 64'd4);

    // illegal MemRW=11 goes straight to WB
    fetch();
    decode(1'b1, 2'b11, 1'b0, 1'b0);
    chk("illegal_memrw_wb", 64'(state_dbg), 64'd5);
    chk("illegal_memrw_no_lsu", 64'(lsu_req_valid), 64'd0);
    tick();
    chk("illegal_instret", instret, 64'd5);

    // ebreak as the sixth instruction
    fetch();
    decode(1'b0, 2'b00, 1'b0, 1'b1);
    chk("ebreak_halt", 64'(halt), 64'd1);
    chk("ebreak_state", 64'(state_dbg), 64'd6);
    chk("ebreak_instret", instret, 64'd6);
    no_fetch = 1;
    for (int i = 0; i < 20; i++) begin
      if (ifu_req_valid || pc_we || rf_we) no_fetch = 0;
      ifu_resp_valid = i[0];
      tick();
    end
    ifu_resp_valid = 1'b0;
    chk("halt_quiet_20", 64'(no_fetch), 64'd1);
    chk("halt_instret_stable", instret, 64'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("halt_rst_halt", 64'(halt), 64'd0);
    chk("halt_rst_instret", instret, 64'd0);
    chk("halt_rst_state", 64'(state_dbg), 64'd0);

    // reset while waiting on a load response
    fetch();
    decode(1'b1, 2'b10, 1'b1, 1'b0);
    lsu_req_ready = 1'b1;
    tick();
    lsu_req_ready = 1'b0;
    chk("mwait_before_rst", 64'(state_dbg), 64'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mwait_rst_state", 64'(state_dbg), 64'd0);
    chk("mwait_rst_lsu_valid", 64'(lsu_req_valid), 64'd0);
    chk("mwait_rst_pc_sel", 64'(pc_sel), 64'd0);
    lsu_resp_valid = 1'b1;
    tick();
    lsu_resp_valid = 1'b0;
    chk("late_resp_no_rf_we", 64'(rf_we), 64'd0);
    chk("late_resp_state", 64'(state_dbg), 64'd0);
    chk("late_resp_instret", instret, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
